uart_rx_buffer: RTL and testbench
=================================

// Module: uart_rx_buffer
// PURPOSE
//  Downstream consumer of the UART receiver. Detects RX_FLAG, captures DATARX plus
//  ParityError into a FIFO, then returns Clear_RX_Flag to the UART. Decouples UART
//  frame timing (16 clk/bit, even parity) from the host, which drains bytes via Pop.
// PARAMETERS
//  WORD_LENGTH        8  data width; matches UART WORD_LENGTH
//  DEPTH_LOG2         4  FIFO depth = 2**DEPTH_LOG2 entries (16)
//  DROP_PARITY_ERR    0  1: bytes with ParityError=1 are discarded, never stored
// PORTS
//  clk            in   1              system clock, rising edge
//  reset          in   1              asynchronous, active-low
//  RX_FLAG        in   1              UART byte-ready flag, held high until cleared
//  DATARX         in   WORD_LENGTH    UART received byte, valid while RX_FLAG=1
//  ParityError    in   1              UART parity status for DATARX
//  Clear_RX_Flag  out  1              one-cycle pulse to UART after capture
//  Pop            in   1              host consumes head entry
//  DataOut        out  WORD_LENGTH    head entry data (first-word fall-through)
//  DataOutPErr    out  1              parity-error tag of head entry
//  Empty          out  1              FIFO holds no entries
//  Full           out  1              FIFO holds 2**DEPTH_LOG2 entries
//  Count          out  DEPTH_LOG2+1   number of stored entries
//  Overflow       out  1              sticky: a byte was lost because FIFO was full
//  Clear_Overflow in   1              clears Overflow
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, pointers=0, Count=0, Empty=1, Full=0,
//   Overflow=0, Clear_RX_Flag=0, DataOut=0, DataOutPErr=0.
//  Capture FSM (registered, all outputs registered):
//   IDLE:     RX_FLAG=1 -> CAPTURE.
//   CAPTURE:  write {ParityError,DATARX} at wr_ptr if accepted; -> CLEAR.
//             Accepted = !Full || Pop (pop same cycle frees slot) and
//             !(DROP_PARITY_ERR && ParityError). Not accepted due to Full -> set
//             Overflow. Dropped for parity -> no write, no Overflow.
//   CLEAR:    Clear_RX_Flag=1 for exactly this cycle; -> WAIT_LOW.
//   WAIT_LOW: Clear_RX_Flag=0; stay until RX_FLAG=0, then -> IDLE.
//             Guarantees one write per UART frame even if flag drop is delayed.
//  Latency: RX_FLAG rise (cycle N) -> entry visible, Empty=0 at cycle N+2;
//   Clear_RX_Flag high in cycle N+2.
//  Read side: DataOut/DataOutPErr always show mem[rd_ptr]; Pop with Empty=0
//   advances rd_ptr at next edge; Pop with Empty=1 ignored (no pointer/Count change).
//  Pointers DEPTH_LOG2 bits, wrap modulo depth. Count: +1 write only, -1 pop only,
//   unchanged on simultaneous write+pop. Full=(Count==depth), Empty=(Count==0).
//  Simultaneous write+pop when Empty: pop ignored, write proceeds, Count=1.
//  Overflow: set on rejected write; Clear_Overflow=1 clears; set wins if both in
//   same cycle. Overflow never blocks further writes after space frees.
//  Reset mid-frame (any state): returns to IDLE, FIFO emptied; if RX_FLAG still 1
//   after reset release, the pending byte is captured normally.
// TESTING
//  1 Reset: hold reset=0 4 clk -> Empty=1, Count=0, Overflow=0, Clear_RX_Flag=0.
//  2 Single byte: serial frame 0x69 parity 0 into UART -> Clear_RX_Flag one pulse,
//    Count=1, DataOut=0x69, DataOutPErr=0; Pop -> Empty=1 next cycle.
//  3 Parity tag: force RX_FLAG with DATARX=0x07, ParityError=1 -> DataOutPErr=1;
//    with DROP_PARITY_ERR=1 -> Count stays 0, Clear_RX_Flag still pulses.
//  4 Fill: push 0x00..0x0F (16 bytes) -> Full=1, Count=16; 17th byte 0xAA ->
//    Overflow=1, Count=16, DataOut=0x00; pop all -> order 0x00..0x0F, Empty=1.
//  5 Wrap/concurrent: with Count=16, byte 0x55 arrives same cycle as Pop ->
//    accepted, Count=16, Overflow=0; 20 push/pop cycles preserve FIFO order.
//  6 Held flag: keep RX_FLAG=1 for 10 clk after Clear_RX_Flag -> exactly one
//    entry written; Clear_Overflow with set event same cycle -> Overflow stays 1.

Source files
------------

// File: rtl/uart_rx_buffer_if.sv
// Signal bundle between the UART receiver, the rx buffer and the host.
// The slave view belongs to the buffer; the master view is the UART/host side.
interface uart_rx_buffer_if #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH_LOG2  = 4
);
  logic                   RX_FLAG;
  logic [WORD_LENGTH-1:0] DATARX;
  logic                   ParityError;
  logic                   Clear_RX_Flag;
  logic                   Pop;
  logic [WORD_LENGTH-1:0] DataOut;
  logic                   DataOutPErr;
  logic                   Empty;
  logic                   Full;
  logic [DEPTH_LOG2:0]    Count;
  logic                   Overflow;
  logic                   Clear_Overflow;

  modport master (
    output RX_FLAG, DATARX, ParityError, Pop, Clear_Overflow,
    input  Clear_RX_Flag, DataOut, DataOutPErr, Empty, Full, Count, Overflow
  );

  modport slave (
    input  RX_FLAG, DATARX, ParityError, Pop, Clear_Overflow,
    output Clear_RX_Flag, DataOut, DataOutPErr, Empty, Full, Count, Overflow
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// Captures each UART byte (plus its parity status) into a first-word fall-through
// FIFO and acknowledges the UART with a one-cycle Clear_RX_Flag pulse.
module uart_rx_buffer #(
  parameter int WORD_LENGTH     = 8,
  parameter int DEPTH_LOG2      = 4,
  parameter bit DROP_PARITY_ERR = 1'b0
) (
  input logic             clk,
  input logic             reset,
  uart_rx_buffer_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef struct packed {
    logic                   perr;
    logic [WORD_LENGTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR, WAIT_LOW} state_t;

  state_t                state;
  entry_t                mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  clear_q, overflow_q;
  logic                  empty, full, do_pop, drop, wr_en, reject;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign do_pop = bus.Pop && !empty;
  assign drop   = DROP_PARITY_ERR && bus.ParityError;
  // A pop in the capture cycle frees the head slot in time for the write.
  assign wr_en  = (state == CAPTURE) && !drop && (!full || do_pop);
  assign reject = (state == CAPTURE) && !drop && full && !do_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      clear_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_q <= 1'b0;
          if (bus.RX_FLAG) state <= CAPTURE;
        end
        CAPTURE: begin
          clear_q <= 1'b1;
          state   <= CLEAR;
        end
        CLEAR: begin
          clear_q <= 1'b0;
          state   <= WAIT_LOW;
        end
        // Holding here until the flag drops keeps it to one write per frame.
        WAIT_LOW: begin
          clear_q <= 1'b0;
          if (!bus.RX_FLAG) state <= IDLE;
        end
        default: begin
          clear_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{perr: bus.ParityError, data: bus.DATARX};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set has priority over a same-cycle clear so no loss goes unreported.
      if (reject)                  overflow_q <= 1'b1;
      else if (bus.Clear_Overflow) overflow_q <= 1'b0;
    end
  end

  assign bus.Clear_RX_Flag = clear_q;
  assign bus.DataOut       = mem[rd_ptr].data;
  assign bus.DataOutPErr   = mem[rd_ptr].perr;
  assign bus.Empty         = empty;
  assign bus.Full          = full;
  assign bus.Count         = count;
  assign bus.Overflow      = overflow_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench: a keep-all buffer and a parity-dropping buffer share one stimulus.
module tb_uart_rx_buffer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_flag = 1'b0, perr = 1'b0, pop = 1'b0, clr_ovf = 1'b0;
  logic [7:0] datarx = 8'h00;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_rx_buffer_if #(.WORD_LENGTH(8), .DEPTH_LOG2(4)) bus0 ();
  uart_rx_buffer_if #(.WORD_LENGTH(8), .DEPTH_LOG2(4)) bus1 ();

  assign bus0.RX_FLAG = rx_flag;  assign bus1.RX_FLAG = rx_flag;
  assign bus0.DATARX = datarx;    assign bus1.DATARX = datarx;
  assign bus0.ParityError = perr; assign bus1.ParityError = perr;
  assign bus0.Pop = pop;          assign bus1.Pop = pop;
  assign bus0.Clear_Overflow = clr_ovf;
  assign bus1.Clear_Overflow = clr_ovf;

  uart_rx_buffer #(.WORD_LENGTH(8), .DEPTH_LOG2(4), .DROP_PARITY_ERR(1'b0))
    dut_keep (.clk(clk), .reset(reset), .bus(bus0));
  uart_rx_buffer #(.WORD_LENGTH(8), .DEPTH_LOG2(4), .DROP_PARITY_ERR(1'b1))
    dut_drop (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         exp_drop_cnt;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rx_flag = 1'b0; pop = 1'b0; clr_ovf = 1'b0; perr = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
  endtask

  // Raise the flag, count acknowledge pulses, drop the flag `hold` cycles after the pulse.
  task automatic send(input logic [7:0] d, input logic p, input int hold,
                      output int pulses, output int lat, output logic emp_at_pulse);
    int since;
    pulses = 0; lat = -1; since = -1; emp_at_pulse = 1'b1;
    @(negedge clk); rx_flag = 1'b1; datarx = d; perr = p;
    for (int i = 0; i < hold + 8; i++) begin
      @(negedge clk);
      if (bus0.Clear_RX_Flag) begin
        pulses++;
        if (since < 0) begin since = 0; lat = i; emp_at_pulse = bus0.Empty; end
      end
      if (since >= 0) begin
        if (since == hold) rx_flag = 1'b0;
        since++;
      end
    end
    rx_flag = 1'b0;
  endtask

  // Frame whose capture cycle coincides with optional Pop / Clear_Overflow.
  task automatic conc_push(input logic [7:0] d, input logic p_pop, input logic p_clr,
                           output int pulses);
    pulses = 0;
    @(negedge clk); rx_flag = 1'b1; datarx = d; perr = 1'b0;
    @(negedge clk); pop = p_pop; clr_ovf = p_clr;
    @(negedge clk); pop = 1'b0; clr_ovf = 1'b0;
    if (bus0.Clear_RX_Flag) pulses++;
    rx_flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus0.Clear_RX_Flag) pulses++;
    end
  endtask

  initial begin
    int pulses, lat;
    logic ep;
    logic [7:0] q [$];

    vecs[0] = '{8'h69, 1'b0, 1};
    vecs[1] = '{8'h07, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b0, 1};
    vecs[3] = '{8'h00, 1'b1, 0};
    vecs[4] = '{8'hA5, 1'b0, 1};

    // Reset state
    do_reset();
    chk("rst_empty", bus0.Empty, 1);
    chk("rst_count", bus0.Count, 0);
    chk("rst_full", bus0.Full, 0);
    chk("rst_ovf", bus0.Overflow, 0);
    chk("rst_clear", bus0.Clear_RX_Flag, 0);
    chk("rst_dout", bus0.DataOut, 0);
    pop_one();
    chk("pop_empty_count", bus0.Count, 0);
    chk("pop_empty_empty", bus0.Empty, 1);

    // Single bytes, parity tagging and parity dropping
    foreach (vecs[k]) begin
      send(vecs[k].data, vecs[k].perr, 0, pulses, lat, ep);
      chk($sformatf("v%0d_pulses", k), pulses, 1);
      chk($sformatf("v%0d_latency", k), lat, 1);
      chk($sformatf("v%0d_empty_at_ack", k), ep, 0);
      chk($sformatf("v%0d_count", k), bus0.Count, 1);
      chk($sformatf("v%0d_dout", k), bus0.DataOut, vecs[k].data);
      chk($sformatf("v%0d_perr", k), bus0.DataOutPErr, vecs[k].perr);
      chk($sformatf("v%0d_drop_count", k), bus1.Count, vecs[k].exp_drop_cnt);
      pop_one();
      chk($sformatf("v%0d_empty_after_pop", k), bus0.Empty, 1);
      chk($sformatf("v%0d_drop_empty", k), bus1.Empty, 1);
    end

    // Fill, overflow, drain in order
    do_reset();
    for (int k = 0; k < 16; k++) send(8'(k), 1'b0, 0, pulses, lat, ep);
    chk("fill_full", bus0.Full, 1);
    chk("fill_count", bus0.Count, 16);
    send(8'hAA, 1'b0, 0, pulses, lat, ep);
    chk("ovf_pulses", pulses, 1);
    chk("ovf_set", bus0.Overflow, 1);
    chk("ovf_count", bus0.Count, 16);
    chk("ovf_head", bus0.DataOut, 8'h00);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_%0d", k), bus0.DataOut, k);
      pop_one();
    end
    chk("drain_empty", bus0.Empty, 1);
    chk("drain_ovf_sticky", bus0.Overflow, 1);

    // Full FIFO with write and pop in the same cycle, then wrap-around traffic
    for (int k = 0; k < 16; k++) begin
      send(8'(8'h10 + k), 1'b0, 0, pulses, lat, ep);
      q.push_back(8'(8'h10 + k));
    end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_cleared", bus0.Overflow, 0);
    chk("conc_head", bus0.DataOut, q[0]);
    void'(q.pop_front());
    conc_push(8'h55, 1'b1, 1'b0, pulses);
    q.push_back(8'h55);
    chk("conc_pulses", pulses, 1);
    chk("conc_count", bus0.Count, 16);
    chk("conc_ovf", bus0.Overflow, 0);
    chk("conc_full", bus0.Full, 1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("wrap_%0d", k), bus0.DataOut, q[0]);
      void'(q.pop_front());
      conc_push(8'(8'h60 + k), 1'b1, 1'b0, pulses);
      q.push_back(8'(8'h60 + k));
    end
    chk("wrap_count", bus0.Count, 16);
    chk("wrap_ovf", bus0.Overflow, 0);

    // Held flag writes once; overflow set beats a same-cycle clear
    do_reset();
    send(8'h3C, 1'b0, 10, pulses, lat, ep);
    chk("held_pulses", pulses, 1);
    chk("held_count", bus0.Count, 1);
    for (int k = 1; k < 16; k++) send(8'(k), 1'b0, 0, pulses, lat, ep);
    conc_push(8'hEE, 1'b0, 1'b1, pulses);
    chk("setclr_pulses", pulses, 1);
    chk("setclr_ovf", bus0.Overflow, 1);
    chk("setclr_count", bus0.Count, 16);
    chk("setclr_head", bus0.DataOut, 8'h3C);
    pop_one();
    send(8'h77, 1'b0, 0, pulses, lat, ep);
    chk("after_ovf_write", bus0.Count, 16);
    chk("after_ovf_head", bus0.DataOut, 8'h01);

    // Reset in the middle of a frame with the flag still high afterwards
    @(negedge clk); rx_flag = 1'b1; datarx = 8'hC3; perr = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("midrst_count", bus0.Count, 0);
    chk("midrst_empty", bus0.Empty, 1);
    chk("midrst_ovf", bus0.Overflow, 0);
    chk("midrst_dout", bus0.DataOut, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus0.Clear_RX_Flag) begin pulses++; rx_flag = 1'b0; end
    end
    rx_flag = 1'b0;
    chk("midrst_pulses", pulses, 1);
    chk("midrst_recount", bus0.Count, 1);
    chk("midrst_redout", bus0.DataOut, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
